// File: rtl/program_loader_pkg.sv
// Shared definitions for the Aeolus writable program store: state encoding
// and default memory geometry.
package program_loader_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_WIDTH = 4;
  localparam int CPU_ADDR_W    = 4;

  typedef enum logic [1:0] {
    RELEASE = 2'd0,
    RUN     = 2'd1,
    LOAD    = 2'd2,
    FULL    = 2'd3
  } state_t;

endpackage

// File: rtl/program_loader_edge_sync.sv
// Synchroniser for one asynchronous board input, with single-cycle rise and
// fall pulses derived from the synchronised level.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift form keeps the chain legal even for a single stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(async_in);
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/program_loader.sv
// Writable program store: loads instructions from switches in LOAD mode and
// serves registered PC fetches to the CPU in every mode.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  loadMode,
  input  logic                  writeStrobe,
  input  logic [WIDTH-1:0]      dataIn,
  input  logic [CPU_ADDR_W-1:0] addressIn,
  output logic [WIDTH-1:0]      dataOut,
  output logic                  cpuReset,
  output logic [CPU_ADDR_W-1:0] writeAddr,
  output logic                  full
);

  localparam int                ADDR_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic load_level, load_rise, load_fall;
  logic strobe_level, strobe_rise, strobe_fall;
  logic unused_edges;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] write_addr_q;
  logic              full_q;
  logic              cpu_reset_q, cpu_reset_d;
  logic              do_write, last_write, enter_load;
  logic [ADDR_W-1:0] rd_addr;

  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (loadMode),
    .level    (load_level),
    .rise     (load_rise),
    .fall     (load_fall)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (writeStrobe),
    .level    (strobe_level),
    .rise     (strobe_rise),
    .fall     (strobe_fall)
  );

  // Mode changes follow the synchronised level, so only strobe rises matter.
  assign unused_edges = ^{load_rise, load_fall, strobe_level, strobe_fall};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RELEASE;
      write_addr_q <= '0;
      full_q       <= 1'b0;
      cpu_reset_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cpu_reset_q <= cpu_reset_d;
      if (enter_load) begin
        write_addr_q <= '0;
        full_q       <= 1'b0;
      end else if (do_write) begin
        write_addr_q <= last_write ? '0 : write_addr_q + 1'b1;
        if (last_write) full_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RELEASE: state_d = RUN;
      RUN:     if (load_level) state_d = LOAD;
      LOAD: begin
        if (!load_level)
          state_d = RELEASE;
        else if (strobe_rise && write_addr_q == LAST_ADDR)
          state_d = FULL;
      end
      FULL:    if (!load_level) state_d = RELEASE;
      default: state_d = RELEASE;
    endcase
  end

  // cpuReset is registered from the next state so the CPU sees a clean level.
  always_comb begin
    do_write    = (state_q == LOAD) && strobe_rise;
    last_write  = do_write && (write_addr_q == LAST_ADDR);
    enter_load  = (state_q == RUN) && load_level;
    cpu_reset_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[write_addr_q] <= dataIn;
  end

  assign rd_addr = ADDR_W'(addressIn);

  always_ff @(posedge clk) begin
    if (reset) dataOut <= '0;
    else       dataOut <= mem[rd_addr];
  end

  assign cpuReset  = cpu_reset_q;
  assign writeAddr = CPU_ADDR_W'(write_addr_q);
  assign full      = full_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: reset, partial and full
// loads, long strobes, coincident edges and reset during a load.
module tb_program_loader;

  logic       clk;
  logic       reset;
  logic       loadMode;
  logic       writeStrobe;
  logic [3:0] dataIn;
  logic [3:0] addressIn;
  logic [3:0] dataOut;
  logic       cpuReset;
  logic [3:0] writeAddr;
  logic       full;

  int checks = 0;
  int errors = 0;

  program_loader dut (
    .clk         (clk),
    .reset       (reset),
    .loadMode    (loadMode),
    .writeStrobe (writeStrobe),
    .dataIn      (dataIn),
    .addressIn   (addressIn),
    .dataOut     (dataOut),
    .cpuReset    (cpuReset),
    .writeAddr   (writeAddr),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One button press: high for 2 cycles, then low long enough to re-arm.
  task automatic applyStimulus(input logic [3:0] data);
    dataIn      = data;
    writeStrobe = 1'b1;
    tick(2);
    writeStrobe = 1'b0;
    tick(4);
  endtask

  task automatic setLoad(input logic value);
    loadMode = value;
    tick(4);
  endtask

  task automatic readCheck(input string tag, input logic [3:0] addr, input logic [3:0] expected);
    addressIn = addr;
    tick(1);
    checkOutput(tag, dataOut, expected);
  endtask

  // After loadMode drops: 2 sync cycles in LOAD, 1 RELEASE cycle, then RUN.
  task automatic checkReleaseSequence(input string tag);
    logic [3:0] expected;
    expected = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checkOutput($sformatf("%s_cpuReset%0d", tag, i), cpuReset, expected[i]);
    end
  endtask

  initial begin
    reset       = 1'b1;
    loadMode    = 1'b0;
    writeStrobe = 1'b0;
    dataIn      = 4'h0;
    addressIn   = 4'h0;
    tick(2);
    checkOutput("rst_cpuReset", cpuReset, 1);
    checkOutput("rst_dataOut", dataOut, 0);
    checkOutput("rst_writeAddr", writeAddr, 0);
    checkOutput("rst_full", full, 0);
    reset = 1'b0;
    tick(1);
    checkOutput("rst_release_done", cpuReset, 0);
    tick(1);
    checkOutput("rst_run_holds", cpuReset, 0);

    // Partial load
    setLoad(1'b1);
    checkOutput("pl_enter_cpuReset", cpuReset, 1);
    checkOutput("pl_enter_writeAddr", writeAddr, 0);
    applyStimulus(4'h3);
    applyStimulus(4'hA);
    applyStimulus(4'h5);
    checkOutput("pl_writeAddr", writeAddr, 3);
    checkOutput("pl_cpuReset", cpuReset, 1);
    checkOutput("pl_full", full, 0);
    loadMode = 1'b0;
    checkReleaseSequence("pl");
    readCheck("pl_rd0", 4'd0, 4'h3);
    readCheck("pl_rd1", 4'd1, 4'hA);
    readCheck("pl_rd2", 4'd2, 4'h5);

    // Full load, then an ignored 17th strobe
    setLoad(1'b1);
    checkOutput("fl_enter_writeAddr", writeAddr, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(4'(i));
      if (i == 14) checkOutput("fl_not_full_yet", full, 0);
    end
    checkOutput("fl_full", full, 1);
    checkOutput("fl_writeAddr_wrap", writeAddr, 0);
    checkOutput("fl_cpuReset", cpuReset, 1);
    applyStimulus(4'h9);
    checkOutput("fl_17th_writeAddr", writeAddr, 0);
    checkOutput("fl_17th_full", full, 1);
    loadMode = 1'b0;
    checkReleaseSequence("fl");
    readCheck("fl_rd0", 4'd0, 4'h0);
    readCheck("fl_rd5", 4'd5, 4'h5);
    readCheck("fl_rd15", 4'd15, 4'hF);

    // Long strobe gives exactly one write
    setLoad(1'b1);
    checkOutput("ls_enter_full", full, 0);
    dataIn      = 4'hC;
    writeStrobe = 1'b1;
    tick(50);
    writeStrobe = 1'b0;
    tick(4);
    checkOutput("ls_writeAddr", writeAddr, 1);
    setLoad(1'b0);
    checkOutput("ls_run_cpuReset", cpuReset, 0);
    readCheck("ls_rd0", 4'd0, 4'hC);
    readCheck("ls_rd1", 4'd1, 4'h1);

    // Strobe in RUN is ignored
    applyStimulus(4'hE);
    checkOutput("run_writeAddr", writeAddr, 1);
    readCheck("run_rd1", 4'd1, 4'h1);
    readCheck("run_rd0", 4'd0, 4'hC);

    // Strobe edge coincident with loadMode falling
    setLoad(1'b1);
    dataIn      = 4'h7;
    loadMode    = 1'b0;
    writeStrobe = 1'b1;
    checkReleaseSequence("sc");
    writeStrobe = 1'b0;
    tick(2);
    checkOutput("sc_writeAddr", writeAddr, 1);
    readCheck("sc_rd0", 4'd0, 4'h7);

    // Reset in the middle of a load
    setLoad(1'b1);
    applyStimulus(4'h6);
    applyStimulus(4'h9);
    checkOutput("rm_writeAddr_before", writeAddr, 2);
    reset    = 1'b1;
    loadMode = 1'b0;
    tick(1);
    checkOutput("rm_cpuReset", cpuReset, 1);
    checkOutput("rm_writeAddr", writeAddr, 0);
    checkOutput("rm_dataOut", dataOut, 0);
    reset = 1'b0;
    tick(1);
    checkOutput("rm_run_cpuReset", cpuReset, 0);
    readCheck("rm_rd0", 4'd0, 4'h6);
    readCheck("rm_rd1", 4'd1, 4'h9);
    readCheck("rm_rd2", 4'd2, 4'h2);
    checkOutput("rm_writeAddr_run", writeAddr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
